// File: rtl/dm_write_logger.sv
// Store-trace capture FIFO for the core's data-memory write port.
// Logs stores until dump rises, then drains them in order over valid/ready.
module dm_write_logger #(
  parameter int N     = 64,
  parameter int DEPTH = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   DM_writeEnable,
  input  logic [N-1:0]           DM_addr,
  input  logic [N-1:0]           DM_writeData,
  input  logic                   dump,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [N-1:0]           out_addr,
  output logic [N-1:0]           out_data,
  output logic [15:0]            out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            dropped,
  output logic                   done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          dump_q;

  logic [N-1:0]  addr_mem [DEPTH];
  logic [N-1:0]  data_mem [DEPTH];
  logic [15:0]   seq_mem  [DEPTH];

  logic capturing;
  logic store;
  logic full;
  logic empty;
  logic push;
  logic drop;
  logic pop;
  logic dump_edge;

  assign capturing = (state_q == CAPTURE);
  assign store     = capturing & DM_writeEnable;
  assign full      = (cnt_q == FULL);
  assign empty     = (cnt_q == '0);
  assign push      = store & ~full;
  assign drop      = store & full;
  assign pop       = out_valid & out_ready;
  assign dump_edge = dump & ~dump_q;

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= CAPTURE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a store on the edge cycle is logged before draining
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CAPTURE: begin
        if (dump_edge) begin
          if (empty && !DM_writeEnable) state_d = DONE;
          else                          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && cnt_q == CW'(1)) state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = CAPTURE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == DRAIN) & ~empty;
    done      = (state_q == DONE);
    out_addr  = '0;
    out_data  = '0;
    out_seq   = '0;
    if (out_valid) begin
      out_addr = addr_mem[rd_ptr_q];
      out_data = data_mem[rd_ptr_q];
      out_seq  = seq_mem[rd_ptr_q];
    end
  end

  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign dropped  = drop_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (store) seq_d = seq_q + 16'd1;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d    = cnt_q + CW'(1);
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      dump_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      dump_q   <= dump;
    end
  end

  // Storage needs no reset; outputs are masked until an entry is valid
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= DM_addr;
      data_mem[wr_ptr_q] <= DM_writeData;
      seq_mem[wr_ptr_q]  <= seq_q;
    end
  end

endmodule

// File: doc/dm_write_logger.md
# dm_write_logger

Capture buffer that sits directly downstream of `processor_arm`'s data-memory write port. It records every store the core issues (`DM_addr`, `DM_writeData` while `DM_writeEnable` is high) into a FIFO. When `dump` rises, it stops capturing and drains the log in program order over a valid/ready stream, so benches and on-board debug can check the store trace instead of relying on a fixed run time.

## Interface
- `N`, default 64: address/data width, matching the core's datapath.
- `DEPTH`, default 16: number of log entries; must be a power of 2, ≥ 2.
- `CLOCK_50`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `DM_writeEnable`  in  1: store strobe from the core; one store per high cycle.
- `DM_addr`  in  N: store address.
- `DM_writeData`  in  N: store data.
- `dump`  in  1: level input; its 0→1 transition starts the drain.
- `out_ready`  in  1: consumer accepts the current entry.
- `out_valid`  out  1: `out_addr`/`out_data`/`out_seq` hold a valid entry.
- `out_addr`  out  N: logged address.
- `out_data`  out  N: logged data.
- `out_seq`  out  16: capture index of the entry, starting at 0.
- `count`  out  $clog2(DEPTH)+1: current occupancy.
- `overflow`  out  1: sticky; at least one store was dropped.
- `dropped`  out  16: number of dropped stores, saturating at 16'hFFFF.
- `done`  out  1: drain complete; held high until reset.

## Operation
- States are `CAPTURE`, `DRAIN` and `DONE`. Reset enters `CAPTURE`.
- **Reset values:** `out_valid`=0, `out_addr`=0, `out_data`=0, `out_seq`=0, `count`=0, `overflow`=0, `dropped`=0, `done`=0. Read/write pointers, sequence counter and `dump` edge register are all cleared.
- **CAPTURE, store with `count` < DEPTH:** write {`DM_addr`, `DM_writeData`, seq} at the write pointer, advance the pointer modulo DEPTH, increment seq.
- **CAPTURE, store with `count` = DEPTH:** drop the store, set `overflow`, increment `dropped` (saturating). seq still increments, so `out_seq` gaps expose the drop position.
- **Dump edge detection:** `dump` is registered; an edge is `dump & ~dump_q`. A level held high does not retrigger.
- **CAPTURE → DRAIN:** on a dump edge. A store in the same cycle as the edge is captured first (or dropped if full).
- **CAPTURE → DONE:** on a dump edge when the FIFO is empty and no store occurs that cycle.
- **DRAIN:**
  - `out_valid` = (`count` ≠ 0); outputs show the entry at the read pointer.
  - A transfer happens when `out_valid` and `out_ready` are both high; the read pointer advances modulo DEPTH.
  - Stores arriving during DRAIN are ignored and are not counted in `dropped`.
  - When the last entry transfers, the next state is `DONE`.
- **DONE:** `done`=1, `out_valid`=0. All inputs except `reset` are ignored; further dump edges have no effect.
- `reset` going low at any time, including mid-drain, clears everything immediately; the log contents are discarded.

## Timing
- Capture latency is 1 cycle: a store sampled at edge k shows in `count` after edge k.
- Dump edge sampled at edge k → state is DRAIN after edge k; `out_valid` can first be high in cycle k+1 (the first cycle after that edge).
- Back-to-back transfers: one entry per cycle while `out_ready`=1.
- While `out_valid`=1 and `out_ready`=0, all `out_*` outputs stay stable.
- Last transfer at edge k → `done`=1 and `out_valid`=0 after edge k.
- `count` changes by at most 1 per cycle. Push and pop never occur in the same cycle, because capture and drain are mutually exclusive states.
- Pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by `count`, not by pointer equality.

## Test plan
- **Basic capture and drain:** reset, 3 stores (0x08→0xA, 0x10→0xB, 0x18→0xC), then dump with `out_ready`=1 → 3 transfers in order, seq 0,1,2, `count` 3→0; `done`=1 on the cycle after the third transfer.
- **Overflow (DEPTH=16):** 20 stores, data = i → `count`=16, `overflow`=1, `dropped`=4; drain returns seq 0..15 with data 0..15.
- **Backpressure:** 2 stores, dump, `out_ready` held 0 for 5 cycles → `out_valid`=1 with entry 0 stable for all 5 cycles; then 2 transfers follow, then `done`.
- **Empty dump, and store on the edge cycle:** dump with no stores → `done`=1 one cycle later, `out_valid` never high. Separately, a store in the same cycle as the dump edge → drained as the last entry.
- **Wrap-around:** 10 stores, drain 10, reset, 16 stores, drain → all 16 entries correct, no `overflow`. Separately, stores during DRAIN → not logged, `dropped` unchanged.
- **Async reset mid-drain:** assert `reset`=0 between clock edges after 2 of 5 transfers → all outputs go to their reset values immediately; after release, state is CAPTURE with `count`=0.
